shift_normalizer: RTL and testbench



---
 rtl/shift_normalizer.sv | 126 ++++++++++++
 tb/tb_shift_normalizer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/shift_normalizer.sv
`default_nettype none
// ============================================================================
// Module      : shift_normalizer
// Description : Iterative normalizer. It shifts a captured word one bit per
//               cycle until the word is normalized: dir=0 until the MSB is set,
//               dir=1 until the LSB is set. It then reports the normalized
//               word, the number of single-bit shifts applied and an all-zero
//               flag. Both sides use valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_normalizer #(
    parameter int WIDTH = 4,
    parameter int SHW   = 2     // must equal $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SHW-1:0]   out_shift,
    output logic             out_zero
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q,    state_d;
    logic [WIDTH-1:0] word_q,     word_d;
    logic             dir_q,      dir_d;
    logic [SHW-1:0]   cnt_q,      cnt_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic [SHW-1:0]   res_shift_q, res_shift_d;
    logic             res_zero_q, res_zero_d;

    logic             word_zero;
    logic             word_norm;

    // The working word is finished once its leading bit (in the chosen
    // direction) is set; an all-zero word never normalizes and is flagged.
    assign word_zero = (word_q == '0);
    assign word_norm = dir_q ? word_q[0] : word_q[WIDTH-1];

    // Accept only in IDLE, and never while reset is held.
    assign in_ready  = rst_n & (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_data  = res_data_q;
    assign out_shift = res_shift_q;
    assign out_zero  = res_zero_q;

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        dir_d       = dir_q;
        cnt_d       = cnt_q;
        res_data_d  = res_data_q;
        res_shift_d = res_shift_q;
        res_zero_d  = res_zero_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    word_d  = in_data;
                    dir_d   = in_dir;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (word_zero) begin
                    res_data_d  = '0;
                    res_shift_d = '0;
                    res_zero_d  = 1'b1;
                    state_d     = S_DONE;
                end else if (word_norm) begin
                    res_data_d  = word_q;
                    res_shift_d = cnt_q;
                    res_zero_d  = 1'b0;
                    state_d     = S_DONE;
                end else begin
                    // A non-zero word needs at most WIDTH-1 shifts, so the
                    // count cannot wrap.
                    word_d = dir_q ? (word_q >> 1) : (word_q << 1);
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                // Result registers are left untouched so they stay visible
                // after the handshake.
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers; asynchronous reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            word_q      <= '0;
            dir_q       <= 1'b0;
            cnt_q       <= '0;
            res_data_q  <= '0;
            res_shift_q <= '0;
            res_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            dir_q       <= dir_d;
            cnt_q       <= cnt_d;
            res_data_q  <= res_data_d;
            res_shift_q <= res_shift_d;
            res_zero_q  <= res_zero_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_normalizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_normalizer
// Description : Directed testbench for shift_normalizer (WIDTH=4) with
//               hand-computed expected results and latencies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_normalizer;

    localparam int WIDTH = 4;
    localparam int SHW   = 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_dir;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [SHW-1:0]   out_shift;
    logic             out_zero;

    int n_cmp;
    int n_err;

    shift_normalizer #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_shift (out_shift),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a word, let it be accepted, and measure cycles to out_valid.
    task automatic start_and_wait(input logic [WIDTH-1:0] d, input logic dir, output int lat);
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_dir   = dir;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = ~d;
        in_dir   = ~dir;
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    // Full transaction: check result, latency and the output handshake.
    task automatic run(input string tag, input logic [WIDTH-1:0] d, input logic dir,
                       input logic [WIDTH-1:0] ed, input logic [SHW-1:0] es,
                       input logic ez, input int elat);
        int lat;
        start_and_wait(d, dir, lat);
        check({tag, "_latency"}, 32'(lat), 32'(elat));
        check({tag, "_data"},    32'(out_data),  32'(ed));
        check({tag, "_shift"},   32'(out_shift), 32'(es));
        check({tag, "_zero"},    32'(out_zero),  32'(ez));
        check({tag, "_busy"},    32'(in_ready),  32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_idle"},       32'(in_ready),  32'd1);
        check({tag, "_data_held"},  32'(out_data),  32'(ed));
    endtask

    initial begin
        int lat;
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_dir    = 1'b0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_shift", 32'(out_shift), 32'd0);
        check("rst_out_zero",  32'(out_zero),  32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Main function
        run("l_0010", 4'b0010, 1'b0, 4'b1000, 2'd2, 1'b0, 3);
        run("r_1100", 4'b1100, 1'b1, 4'b0011, 2'd2, 1'b0, 3);
        run("l_0000", 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b1, 1);
        run("r_0000", 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b1, 1);
        run("l_1001", 4'b1001, 1'b0, 4'b1001, 2'd0, 1'b0, 1);
        run("l_0001", 4'b0001, 1'b0, 4'b1000, 2'd3, 1'b0, 4);
        run("r_1000", 4'b1000, 1'b1, 4'b0001, 2'd3, 1'b0, 4);
        run("l_0110", 4'b0110, 1'b0, 4'b1100, 2'd1, 1'b0, 2);
        run("r_0101", 4'b0101, 1'b1, 4'b0101, 2'd0, 1'b0, 1);

        // Backpressure: hold result for 5 cycles with in_valid pulses
        start_and_wait(4'b0010, 1'b0, lat);
        check("bp_latency", 32'(lat), 32'd3);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            in_data  = 4'b0101;
            in_dir   = 1'b1;
            @(posedge clk);
            #1;
            check("bp_valid",    32'(out_valid), 32'd1);
            check("bp_data",     32'(out_data),  32'b1000);
            check("bp_shift",    32'(out_shift), 32'd2);
            check("bp_zero",     32'(out_zero),  32'd0);
            check("bp_in_ready", 32'(in_ready),  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready),  32'd1);
        run("bp_next", 4'b0100, 1'b1, 4'b0001, 2'd2, 1'b0, 3);

        // Reset in the middle of SHIFT aborts the operation
        check("mr_ready_before", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = 4'b0001;
        in_dir   = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mr_in_ready",  32'(in_ready),  32'd0);
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_out_data",  32'(out_data),  32'd0);
        check("mr_out_shift", 32'(out_shift), 32'd0);
        check("mr_out_zero",  32'(out_zero),  32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("mr_release_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("mr_no_stale_valid", 32'(out_valid), 32'd0);
        end
        run("mr_after", 4'b0011, 1'b0, 4'b1100, 2'd2, 1'b0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
